// File: rtl/mem_responder.sv
// mem_responder
//   Bus-side memory model for the core's valid/ready memory port. Holds a
//   word-addressed backing store with byte-strobe writes and answers each
//   request after a latency between MIN_LATENCY+1 and MAX_LATENCY+1 cycles.
//   The exact latency is chosen by the environment through `stall`.
//   Accesses outside [BASE, BASE + 4*DEPTH) are flagged with `fault`.
//
// Optional feature: define MEM_RESPONDER_ASSERT_EN to enable core-protocol
//   checking (sticky `protocol_err`, plus immediate asserts under FORMAL).
//   Without it `protocol_err` is tied low.
//
// Ports
//   clock, reset  single clock, synchronous active-high reset
//   mem_valid     core request
//   mem_instr     request is an instruction fetch (captured, checked only)
//   mem_addr      byte address
//   mem_wdata     write data
//   mem_wstrb     byte write enables, 0 = read
//   stall         environment delay request, only looked at in WAIT
//   mem_ready     one-cycle response strobe (registered)
//   mem_rdata     read data, zero outside the response cycle (registered)
//   fault         out-of-range pulse alongside mem_ready (registered)
//   req_count     completed transactions, wraps modulo 2^16
//   protocol_err  sticky core-protocol violation flag
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned MIN_LATENCY = 1,
  parameter int unsigned MAX_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        stall,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic [15:0] req_count,
  output logic        protocol_err
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Byte span of the store; 33 bits so BASE + span can never wrap.
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [7:0]  MIN_L = 8'(MIN_LATENCY);
  localparam logic [7:0]  MAX_L = 8'(MAX_LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        capture;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        instr_reg;

  logic        mem_ready_reg;
  logic        fault_reg;
  logic [15:0] req_count_reg;

  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] word_idx;
  logic        respond;
  logic        enter_resp;
  logic        write_en;

  // Address decode works entirely on the captured request, so the core may
  // not influence the response once the request has been accepted.
  assign offset   = addr_reg - BASE;
  assign in_range = (addr_reg >= BASE) && ({1'b0, offset} < SPAN);
  assign word_idx = offset[AW+1:2];

  // A stalled request is still released once the maximum latency is hit.
  assign respond  = (cnt_reg >= MIN_L) && (!stall || (cnt_reg == MAX_L));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_valid) begin
          capture    = 1'b1;
          cnt_next   = 8'd1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (respond) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_reg == WAIT) && respond;
  // Reset during the response cycle abandons the write as well.
  assign write_en   = !reset && (state_reg == RESP) && in_range;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      wstrb_reg     <= 4'd0;
      instr_reg     <= 1'b0;
      mem_ready_reg <= 1'b0;
      fault_reg     <= 1'b0;
      req_count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        addr_reg  <= mem_addr;
        wdata_reg <= mem_wdata;
        wstrb_reg <= mem_wstrb;
        instr_reg <= mem_instr;
      end
      // Outputs are registered: they are computed on the edge into RESP.
      mem_ready_reg <= enter_resp;
      fault_reg     <= enter_resp && !in_range;
      if (state_reg == RESP) begin
        req_count_reg <= req_count_reg + 16'd1;
      end
    end
  end

  // One byte-wide store per lane so each lane infers a plain RAM with its
  // own write enable. The read is taken on the edge into RESP, before the
  // write of that same transaction lands at the end of RESP, so a write
  // transaction returns the old word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clock) begin
        if (write_en && wstrb_reg[gi]) begin
          lane_mem[word_idx] <= wdata_reg[8*gi +: 8];
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          rd_reg <= 8'd0;
        end else if (enter_resp && in_range) begin
          rd_reg <= lane_mem[word_idx];
        end else begin
          rd_reg <= 8'd0;
        end
      end

      assign mem_rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

  assign mem_ready = mem_ready_reg;
  assign fault     = fault_reg;
  assign req_count = req_count_reg;

`ifdef MEM_RESPONDER_ASSERT_EN
  logic perr_reg;
  logic ready_d_reg;
  logic mismatch;

  // While a request is outstanding the core must hold it steady.
  assign mismatch = ((state_reg == WAIT) || (state_reg == RESP)) &&
                    (!mem_valid || (mem_addr != addr_reg) ||
                     (mem_wdata != wdata_reg) || (mem_wstrb != wstrb_reg) ||
                     (mem_instr != instr_reg));

  always_ff @(posedge clock) begin
    if (reset) begin
      perr_reg    <= 1'b0;
      ready_d_reg <= 1'b0;
    end else begin
      if (mismatch) begin
        perr_reg <= 1'b1;
      end
      ready_d_reg <= mem_ready_reg;
    end
  end

`ifdef FORMAL
  always_comb begin
    if (!reset) begin
      assert (!mismatch);
      assert (!(mem_ready_reg && ready_d_reg));
    end
  end
`endif

  assign protocol_err = perr_reg;
`else
  assign protocol_err = 1'b0;
`endif

  // Bits that are decoded or captured but not otherwise consumed.
  logic unused_bits;
  assign unused_bits = ^{instr_reg, offset[31:AW+2], offset[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases followed by
// randomized transactions, checked against a word-array reference model.
module tb_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h100;
  localparam int unsigned MINL  = 1;
  localparam int unsigned MAXL  = 4;

`ifdef MEM_RESPONDER_ASSERT_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        stall;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        fault;
  logic [15:0] req_count;
  logic        protocol_err;

  mem_responder #(
    .DEPTH(DEPTH), .BASE(BASE), .MIN_LATENCY(MINL), .MAX_LATENCY(MAXL)
  ) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall(stall), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .fault(fault), .req_count(req_count), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain word array plus a transaction counter.
  logic [31:0] model_mem [DEPTH];
  int          model_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go_idle(input int cycles);
    @(posedge clock); #1;
    mem_valid = 1'b0;
    stall     = 1'b0;
    mem_wstrb = 4'd0;
    repeat (cycles) @(posedge clock);
  endtask

  // stall_vec[k] is the stall level driven in the k-th cycle after capture.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [7:0] stall_vec);
    int          exp_n;
    int          n;
    logic        in_rng;
    int          idx;
    logic [31:0] exp_rd;

    // Latency: first cycle at or beyond the minimum without a stall,
    // otherwise forced out at the maximum; plus the capture cycle.
    exp_n = MAXL + 1;
    for (int k = MINL; k <= MAXL; k++) begin
      if (!stall_vec[k]) begin
        exp_n = k + 1;
        break;
      end
    end
    in_rng = ({1'b0, addr} >= {1'b0, BASE}) &&
             ({1'b0, addr} <  {1'b0, BASE} + 33'(4 * DEPTH));
    idx    = int'((addr - BASE) >> 2) % DEPTH;
    exp_rd = in_rng ? model_mem[idx] : 32'd0;

    @(posedge clock); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = 1'($urandom % 2);
    stall     = stall_vec[0];
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      stall = (k < 8) ? stall_vec[k[2:0]] : 1'b0;
      @(negedge clock);
      if (mem_ready) begin
        n = k;
        break;
      end
    end

    check("latency", 32'(n), 32'(exp_n));
    if (wstrb == 4'd0 || !in_rng) check("rdata", mem_rdata, exp_rd);
    check("fault", 32'(fault), 32'(!in_rng));
    check("req_count", 32'(req_count), 32'(model_cnt[15:0]));
    $display("txn addr=%h wdata=%h wstrb=%h stall=%b latency=%0d rdata=%h fault=%b",
             addr, wdata, wstrb, stall_vec, n, mem_rdata, fault);

    if (n != 0) begin
      if (in_rng) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      model_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          r;

    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'd0;
    mem_wdata = 32'd0; mem_wstrb = 4'd0; stall = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", 32'(req_count), 32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);

    // Directed cases.
    do_txn(32'h104, 32'hDEADBEEF, 4'hF, 8'h00);
    do_txn(32'h104, 32'h0, 4'h0, 8'h00);
    check("dir_deadbeef", model_mem[1], 32'hDEADBEEF);
    do_txn(32'h104, 32'h0000_0055, 4'b0001, 8'h00);
    do_txn(32'h104, 32'h0, 4'h0, 8'h00);
    do_txn(32'h140, 32'h0, 4'h0, 8'h00);
    go_idle(2);
    do_txn(32'h104, 32'h0, 4'h0, 8'hFF);
    do_txn(32'h104, 32'h0, 4'h0, 8'b0000_0011);
    check("dir_byte_merge", model_mem[1], 32'hDEADBE55);

    // Give every word a known value before random traffic.
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(BASE + 32'(4 * i), $urandom, 4'hF, 8'(($urandom)));
    end

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom % 10);
      if (r < 8)       a = BASE + 32'(4 * ($urandom % DEPTH)) + 32'($urandom % 4);
      else if (r == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * ($urandom % 16));
      else             a = BASE - 32'd4 - 32'(4 * ($urandom % 8));
      s = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
      do_txn(a, $urandom, s, 8'($urandom));
      if ($urandom % 3 == 0) go_idle(int'($urandom % 3));
    end
    check("perr_clean", 32'(protocol_err), 32'd0);

    // Reset in WAIT of a write to 0x108: nothing is written or counted.
    go_idle(1);
    @(posedge clock); #1;
    mem_valid = 1'b1; mem_addr = 32'h108; mem_wdata = ~model_mem[2];
    mem_wstrb = 4'hF; stall = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; mem_valid = 1'b0; stall = 1'b0;
    model_cnt = 0;
    @(negedge clock);
    check("rstw_count", 32'(req_count), 32'd0);
    check("rstw_rdata", mem_rdata, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("rstw_no_ready", 32'(mem_ready), 32'd0);
    end
    do_txn(32'h108, 32'h0, 4'h0, 8'h00);

    // Address changes while the request is outstanding.
    @(posedge clock); #1;
    mem_valid = 1'b1; mem_addr = 32'h10C; mem_wstrb = 4'h0; stall = 1'b1;
    @(posedge clock); #1 mem_addr = 32'h110;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    check("perr_set", 32'(protocol_err), 32'(EXP_PERR));
    stall = 1'b0;
    r = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (mem_ready) begin
        r = 1;
        break;
      end
    end
    check("perr_txn_done", 32'(r), 32'd1);
    go_idle(2);
    @(negedge clock);
    check("perr_sticky", 32'(protocol_err), 32'(EXP_PERR));
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("perr_cleared", 32'(protocol_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Parametrised bus-side memory model for the core's valid/ready memory port, used in formal harnesses and simulation benches in place of free-running random `mem_ready`/`mem_rdata`. It holds a word-addressed backing store with byte-strobe writes, returns responses after a bounded latency chosen by an external stall input, and flags out-of-range accesses. It sits between the `riscv` core's memory port and the harness top, with all memory signals named exactly as on the core.

## Interface

- `DEPTH`, 256: backing store size in 32-bit words; power of two, ≥ 2.
- `BASE`, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `MIN_LATENCY`, 1: minimum cycles from request capture to `mem_ready`; ≥ 1.
- `MAX_LATENCY`, 4: maximum cycles from request capture to `mem_ready`; ≥ `MIN_LATENCY`, ≤ 255.

- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  core request.
- `mem_instr`  in  1  request is an instruction fetch (captured, checked only).
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0 = read.
- `stall`  in  1  environment delay request (free/rand in formal).
- `mem_ready`  out  1  one-cycle response strobe.
- `mem_rdata`  out  32  read data, valid while `mem_ready`.
- `fault`  out  1  one-cycle pulse with `mem_ready` on an out-of-range access.
- `req_count`  out  16  completed transactions, wraps modulo 2^16.
- `protocol_err`  out  1  sticky core-protocol violation flag.

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: if `mem_valid`, capture addr/wdata/wstrb/instr, load `cnt` = 1, go WAIT. Otherwise stay.
- WAIT: respond condition = `cnt ≥ MIN_LATENCY` and (`!stall` or `cnt == MAX_LATENCY`). If true go RESP; else `cnt` += 1.
- RESP: `mem_ready` = 1 for exactly this cycle; next state IDLE.
- In range: `BASE ≤ addr < BASE + 4*DEPTH`; word index = `(addr − BASE) >> 2`; `addr[1:0]` ignored.
- Read in RESP: `mem_rdata` = stored word (value before any write this cycle).
- Write in RESP: each byte `i` with `wstrb[i]` set updated from `wdata[8i+7:8i]`; others unchanged. Write occurs only in RESP.
- Out of range: no store access, `mem_rdata` = 0, `fault` = 1 in RESP cycle.
- `req_count` increments at the end of every RESP cycle.
- Backing store is not reset; contents are unconstrained in formal, X in simulation until written.

## Timing

- Reset values: `mem_ready` 0, `mem_rdata` 0, `fault` 0, `req_count` 0, `protocol_err` 0, state IDLE, `cnt` 0.
- `mem_ready`, `mem_rdata`, `fault` are registered; `mem_rdata` and `fault` are 0 outside RESP.
- Request first seen in IDLE at cycle t → `mem_ready` at cycle t + N, `MIN_LATENCY+1 ≤ N ≤ MAX_LATENCY+1` (one cycle of capture, then WAIT). With `stall` held 0: N = `MIN_LATENCY+1`. With `stall` held 1: N = `MAX_LATENCY+1`.
- Back-to-back: next request accepted at earliest t + N + 1; `mem_valid` still high in the IDLE cycle after RESP is treated as a new request.
- `stall` is ignored outside WAIT.
- Reset in any state: transaction abandoned, no write, no `mem_ready`, all outputs to reset values next cycle.
- `req_count` 16'hFFFF + 1 → 16'h0000.

## Configuration

- `MEM_RESPONDER_ASSERT_EN` defined: in WAIT and RESP, `mem_valid` must stay 1 and `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_instr` must equal captured values; any mismatch sets `protocol_err` (sticky until reset) and, under `FORMAL`, fails an immediate `assert`. Also asserts `mem_ready` never high two consecutive cycles.
- Not defined: no checking logic; `protocol_err` tied 0.

## Test plan

DEPTH=16, BASE=32'h100, MIN_LATENCY=1, MAX_LATENCY=4 unless noted.
- Write 32'hDEADBEEF to 0x104 wstrb 4'hF, stall=0 → `mem_ready` 2 cycles after capture; read 0x104 → `mem_rdata` 32'hDEADBEEF, `fault` 0.
- Write 32'h0000_0055 to 0x104 wstrb 4'b0001 over prior value → read returns 32'hDEADBE55.
- Read 0x140 (just past end) → `mem_ready` with `mem_rdata` 0, `fault` 1 for one cycle; store unchanged.
- stall held 1 → `mem_ready` exactly 5 cycles after capture; stall toggled 1,1,0 → ready 4 cycles after capture.
- Reset asserted in WAIT of a write to 0x108 → no `mem_ready`, subsequent read of 0x108 returns prior value; `req_count` 0.
- With `MEM_RESPONDER_ASSERT_EN`: change `mem_addr` during WAIT → `protocol_err` 1 next cycle and held until reset; without macro → stays 0.
